initial_pop_router: RTL
=======================

# initial_pop_router

Parametrised successor to the transmit-layer initial pop logic. It pops the main FIFO when no virtual channel is paused and the FIFO is not empty. Each returned word is demultiplexed to one of NUM_VC virtual-channel FIFOs, selected by a field in the word. A one-entry skid register absorbs a word whose destination VC pauses while the word is in flight, so no word is lost or reordered. A wrapping pop counter is provided for debug.

## Interface
- DATA_WIDTH, 6, width of main-FIFO words and of data_out
- NUM_VC, 2, number of virtual channels (2..8)
- SEL_W, 1, width of VC select field, must be ≥ clog2(NUM_VC); field is data[DATA_WIDTH-1 -: SEL_W]
- CNT_W, 8, width of pop_count
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- empty_main_fifo  in  1  main FIFO empty flag
- data_main_fifo  in  DATA_WIDTH  main FIFO read data, valid the cycle after a pop (read latency 1)
- pause_vc  in  NUM_VC  per-VC pause (almost-full) from VC FIFOs
- pop_main_fifo  out  1  main FIFO read enable, combinational
- valid_pop_out  out  1  registered; high when data_main_fifo carries a popped word this cycle
- push_vc  out  NUM_VC  registered one-hot push to VC FIFOs
- data_out  out  DATA_WIDTH  registered word accompanying push_vc
- err_route  out  1  registered one-cycle pulse: word had select ≥ NUM_VC, word dropped
- pop_count  out  CNT_W  number of pops since reset, wraps modulo 2^CNT_W

## Operation
- Definitions:
  - sel = data_main_fifo[DATA_WIDTH-1 -: SEL_W].
  - arrive = valid_pop_out.
  - skid_full: internal flag.
  - skid_sel: internal register holding the select field of the skid word.
- pop_main_fifo = !reset & !empty_main_fifo & !(|pause_vc) & !skid_full & !(arrive & sel < NUM_VC & pause_vc[sel]).
- valid_pop_out <= pop_main_fifo. The legacy one-cycle-delayed valid is preserved.
- On arrive with sel ≥ NUM_VC:
  - word dropped.
  - err_route <= 1 next cycle.
  - no push.
- On arrive with pause_vc[sel] = 0: push_vc[sel] <= 1 and data_out <= data_main_fifo.
- On arrive with pause_vc[sel] = 1:
  - word captured into skid, skid_full <= 1.
  - no push that cycle.
- Skid drain: when skid_full and pause_vc[skid_sel] = 0:
  - push_vc[skid_sel] <= 1, data_out <= skid word.
  - skid_full <= 0.
  - Pops are blocked while skid_full, so drain never coincides with an arrival.
- Control states, derived from valid_pop_out and skid_full:
  - IDLE: nothing in flight.
  - FLIGHT: word arriving this cycle.
  - HOLD: skid occupied.
  - FLIGHT and HOLD are mutually exclusive by construction.
- When no push occurs, push_vc = 0; data_out holds its previous value.
- pop_count increments by 1 on every cycle with pop_main_fifo = 1, wrapping from 2^CNT_W−1 to 0.

## Timing
- Reset (any cycle, including mid-transfer): at the next edge:
  - valid_pop_out, push_vc, err_route and skid_full = 0.
  - data_out and pop_count = 0.
  - pop_main_fifo = 0 combinationally while reset is high.
  - In-flight and skid words are discarded.
- Latency from pop at cycle t:
  - data and valid_pop_out at t+1.
  - push_vc/data_out at t+2 when the destination is unpaused at t+1.
- Back-to-back pops: one word per cycle while the FIFO is non-empty and no VC is paused.
- Pause sampling:
  - Pause is evaluated at pop time (any VC blocks the pop) and again at arrival (destination only).
  - Downstream pause thresholds must leave ≥ 2 words of margin, because push lands at t+2.
- Skid fill at cycle u: the earliest following push is u+1, the first cycle with the destination unpaused after the skid fills. Pops resume the cycle after drain.
- Empty: pop_main_fifo = 0 immediately when empty_main_fifo = 1; no underflow pop is ever issued.

## Test plan
- Reset, then 4 words to VC0 (sel=0, data 0x01..0x04), no pause:
  - pops at cycles 1-4, pushes to VC0 at cycles 3-6 in order.
  - pop_count = 4.
- Words alternating sel 0/1, pause_vc = 2'b01 asserted mid-stream:
  - pop stops the same cycle.
  - the in-flight VC0 word goes to skid.
  - deassert pause → skid pushed to VC0 first, then popping resumes with order preserved.
- Word with sel=1 in flight and pause_vc[1] rising at arrival:
  - skid holds the word for 5 paused cycles with push_vc = 0.
  - drain occurs on the first unpaused cycle.
- NUM_VC=3, SEL_W=2, word with sel=3:
  - err_route pulses once, no push, next word routed normally.
- Assert reset for 1 cycle while skid is full and a pop is in flight:
  - all outputs and pop_count are 0 next cycle.
  - the skid word is never pushed.
- CNT_W=4, 18 pops: pop_count = 2.

Source files
------------

// File: rtl/initial_pop_router_if.sv
// initial_pop_router_if: main-FIFO read side and VC-FIFO push side of the pop router
interface initial_pop_router_if #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_VC = 2,
  parameter int CNT_W = 8
);
  logic empty_main_fifo;
  logic [DATA_WIDTH-1:0] data_main_fifo;
  logic [NUM_VC-1:0] pause_vc;
  logic pop_main_fifo;
  logic valid_pop_out;
  logic [NUM_VC-1:0] push_vc;
  logic [DATA_WIDTH-1:0] data_out;
  logic err_route;
  logic [CNT_W-1:0] pop_count;
  modport master (
    input empty_main_fifo, data_main_fifo, pause_vc,
    output pop_main_fifo, valid_pop_out, push_vc, data_out, err_route, pop_count
  );
  modport slave (
    output empty_main_fifo, data_main_fifo, pause_vc,
    input pop_main_fifo, valid_pop_out, push_vc, data_out, err_route, pop_count
  );
endinterface

// File: rtl/initial_pop_router.sv
// initial_pop_router: pops the main FIFO and demuxes each word to a VC FIFO through a one-entry skid
module initial_pop_router #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_VC = 2,
  parameter int SEL_W = 1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  initial_pop_router_if.master bus
);
  localparam int SN = 1 << SEL_W;
  typedef enum logic [1:0] {IDLE, FLIGHT, HOLD} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] skid;
  logic [SEL_W-1:0] sel, skid_sel;
  logic [SN-1:0] pause_ext;
  logic arrive, skid_full, sel_ok, dest_paused, skid_paused, pop;
  always_comb begin
    sel = bus.data_main_fifo[DATA_WIDTH-1 -: SEL_W];
    pause_ext = SN'(bus.pause_vc);
    arrive = state == FLIGHT;
    skid_full = state == HOLD;
    sel_ok = int'(sel) < NUM_VC;
    dest_paused = arrive & sel_ok & pause_ext[sel];
    skid_paused = pause_ext[skid_sel];
    pop = !reset & !bus.empty_main_fifo & !(|bus.pause_vc) & !skid_full & !dest_paused;
  end
  assign bus.pop_main_fifo = pop;
  // a drain and an arrival never share a cycle because pops stall while the skid is occupied
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      skid <= '0;
      skid_sel <= '0;
      bus.valid_pop_out <= 1'b0;
      bus.push_vc <= '0;
      bus.data_out <= '0;
      bus.err_route <= 1'b0;
      bus.pop_count <= '0;
    end else begin
      state <= pop ? FLIGHT : (dest_paused | (skid_full & skid_paused)) ? HOLD : IDLE;
      bus.valid_pop_out <= pop;
      bus.err_route <= arrive & !sel_ok;
      bus.pop_count <= bus.pop_count + CNT_W'(pop);
      bus.push_vc <= '0;
      if (dest_paused) begin
        skid <= bus.data_main_fifo;
        skid_sel <= sel;
      end
      if (arrive & sel_ok & !dest_paused) begin
        bus.push_vc <= NUM_VC'(1) << sel;
        bus.data_out <= bus.data_main_fifo;
      end
      if (skid_full & !skid_paused) begin
        bus.push_vc <= NUM_VC'(1) << skid_sel;
        bus.data_out <= skid;
      end
    end
  end
endmodule
